cordic_sched: RTL and testbench
===============================

CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one cordic instance.
REQ-002 Parameter CORDIC_LATENCY, default 16: cycles from cordic valid_in to valid_out.
REQ-003 Parameter ID_W, default $clog2(NUM_REQ): width of requester tag.
REQ-004 clock  in  1  sole clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 req_valid  in  NUM_REQ  per-requester angle valid.
REQ-007 req_rad  in  NUM_REQ x 32  per-requester fixed-point angle.
REQ-008 req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i] and req_ready[i] are both high.
REQ-009 hold  in  1  downstream backpressure; blocks new grants only.
REQ-010 cord_rad  out  32  angle to cordic.
REQ-011 cord_valid_in  out  1  issue strobe to cordic.
REQ-012 cord_s_out, cord_c_out  in  16 each  cordic results.
REQ-013 cord_valid_out  in  1  cordic result strobe.
REQ-014 res_valid  out  NUM_REQ  one-hot result strobe, one cycle.
REQ-015 res_sin, res_cos  out  16 each  shared result bus.
REQ-016 res_id  out  ID_W  requester tag of current result.
REQ-017 in_flight  out  $clog2(CORDIC_LATENCY+2)  count of issued, not-yet-returned angles.
REQ-018 tag_err  out  1  sticky tag/strobe mismatch flag.

Function
REQ-019 Grant round-robin: priority starts at the requester after the last granted one; after reset, requester 0 has highest priority.
REQ-020 At most one req_ready bit is high per cycle; req_ready is combinational from req_valid, hold, and the RR pointer.
REQ-021 When hold=1, req_ready=0; in-flight items still complete and deliver results.
REQ-022 A transfer in cycle t drives cord_rad=req_rad[i] and cord_valid_in=1 in cycle t+1, both registered.
REQ-023 Without a transfer, cord_valid_in=0 and cord_rad holds its last value.
REQ-024 The RR pointer advances only on a transfer; an idle cycle leaves it unchanged.
REQ-025 A tag shift register of depth CORDIC_LATENCY carries {valid, id} alongside each issue and is aligned with cord_valid_out.
REQ-026 On cord_valid_out=1 with a valid tag head, res_sin, res_cos, res_id and res_valid[id] register in the next cycle.
REQ-027 End-to-end latency is a transfer in cycle t to res_valid in cycle t+CORDIC_LATENCY+2.
REQ-028 Sustained throughput is one angle per cycle across all requesters with no bubbles.
REQ-029 in_flight increments on issue and decrements on result.
REQ-030 A simultaneous issue and result leaves in_flight unchanged.
REQ-031 tag_err sets when cord_valid_out differs from the tag head valid bit.
REQ-032 tag_err stays set until reset.
REQ-033 On a mismatch no res_valid pulses; the pipeline keeps running.
REQ-034 With a single requester continuously valid, that requester is granted every cycle unless hold=1.
REQ-035 Results return strictly in issue order; no reordering.

Reset
REQ-036 While reset=0, all of the following SHALL be 0: req_ready, cord_valid_in, cord_rad, res_valid, res_sin, res_cos, res_id, in_flight, tag_err, all tag valid bits, and the RR pointer.
REQ-037 Reset asserted mid-operation SHALL discard all in-flight tags; cordic results arriving after reset release with no tag SHALL set tag_err.
REQ-038 Reset SHALL apply asynchronously on assertion, with release synchronous to clock.

Structure
REQ-039 A shared package cordic_pkg SHALL hold the NUM_REQ and CORDIC_LATENCY defaults, the ID_W derivation, and the tag struct {valid, id}.
REQ-040 Round-robin grant logic SHALL be a sub-module rr_arbiter with inputs req and advance and a one-hot grant output.
REQ-041 The cordic itself SHALL stay outside this block and connect through the cord_* ports.

Verification
REQ-042 Single request: req_valid=0001, req_rad=0x3243F6A8 -> cord_valid_in one cycle later; res_valid=0001, res_id=0 at CORDIC_LATENCY+2 cycles; in_flight returns to 0.
REQ-043 All four requesters valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; res_id follows the same order; in_flight peaks at 8 or less.
REQ-044 hold=1 for 5 cycles mid-stream -> no req_ready during hold; earlier issues still return; RR order resumes from the next requester.
REQ-045 Stub cordic drops one valid_out -> tag_err=1 that cycle and stays set; the corresponding res_valid is absent.
REQ-046 reset=0 asserted with 6 items in flight -> all outputs 0 immediately; after release, stale cord_valid_out sets tag_err and no res_valid pulses.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC request scheduler.
// Holds the default requester count and CORDIC latency, the requester-tag width derivation,
// and the {valid, id} tag that travels alongside each angle issued to the CORDIC.
package cordic_pkg;

  localparam int unsigned NumReqDefault        = 4;
  localparam int unsigned CordicLatencyDefault = 16;

  // The tag struct carries a fixed-width id so it can be a package-level type; only the low
  // ID_W bits are meaningful.
  localparam int unsigned TagIdW = 8;

  typedef struct packed {
    logic              valid;
    logic [TagIdW-1:0] id;
  } tag_t;

  // Requester tag width; a single requester still gets a 1-bit tag so no vector collapses.
  function automatic int unsigned id_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a one-hot grant.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   req_i          per-requester request vector
//   advance_i      a grant was accepted this cycle; move priority past the winner
//   gnt_o          one-hot grant (combinational)
//   gnt_id_o       index of the granted requester
// Priority starts at ptr_q and wraps; ptr_q resets to 0 so requester 0 wins first.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] idx;
  logic            found;

  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = idx;
      end
    end
  end

  // Idle cycles leave the pointer alone; only an accepted grant moves it.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = (32'(gnt_id_o) + 1 >= NUM_REQ) ? '0 : ID_W'(32'(gnt_id_o) + 1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// Shares one external CORDIC between NUM_REQ requesters.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_valid_i/req_rad_i  per-requester angle handshake (input side)
//   req_ready_o            one-hot round-robin grant, combinational
//   hold_i                 backpressure: blocks new grants, in-flight work still completes
//   cord_rad_o             registered angle to the CORDIC
//   cord_valid_in_o        registered issue strobe to the CORDIC
//   cord_s_out_i/c_out_i   CORDIC results, qualified by cord_valid_out_i
//   res_valid_o            one-hot result strobe to the owning requester
//   res_sin_o/res_cos_o    shared result bus, res_id_o names the owner
//   in_flight_o            issued angles whose tag has not yet reached the pipe head
//   tag_err_o              sticky: CORDIC strobe disagreed with the expected tag
// A tag shift register mirrors the CORDIC pipeline so each result is matched to its owner
// without the CORDIC carrying any sideband; results therefore return in issue order.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = NumReqDefault,
  parameter  int unsigned CORDIC_LATENCY = CordicLatencyDefault,
  parameter  int unsigned ID_W           = id_width(NUM_REQ),
  localparam int unsigned IfW            = $clog2(CORDIC_LATENCY + 2)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ-1:0][31:0] req_rad_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic                    hold_i,
  output logic [31:0]             cord_rad_o,
  output logic                    cord_valid_in_o,
  input  logic [15:0]             cord_s_out_i,
  input  logic [15:0]             cord_c_out_i,
  input  logic                    cord_valid_out_i,
  output logic [NUM_REQ-1:0]      res_valid_o,
  output logic [15:0]             res_sin_o,
  output logic [15:0]             res_cos_o,
  output logic [ID_W-1:0]         res_id_o,
  output logic [IfW-1:0]          in_flight_o,
  output logic                    tag_err_o
);

  logic [NUM_REQ-1:0] arb_req, gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               xfer;

  logic               cord_valid_in_q;
  logic [31:0]        cord_rad_q;
  logic [ID_W-1:0]    issue_id_q;

  tag_t               tag_q [CORDIC_LATENCY];
  tag_t               head;
  logic               res_hit;
  logic               unused_tag_id;

  logic [NUM_REQ-1:0] res_valid_q, res_valid_d;
  logic [15:0]        res_sin_q, res_sin_d, res_cos_q, res_cos_d;
  logic [ID_W-1:0]    res_id_q, res_id_d;
  logic [IfW-1:0]     in_flight_q, in_flight_d;
  logic               tag_err_q, tag_err_d;

  // Reset also masks the grant so req_ready stays low while reset is held.
  assign arb_req = req_valid_i & {NUM_REQ{rst_ni & ~hold_i}};

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (arb_req),
    .advance_i (xfer),
    .gnt_o     (gnt),
    .gnt_id_o  (gnt_id)
  );

  assign xfer        = |gnt;
  assign req_ready_o = gnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cord_valid_in_q <= 1'b0;
      cord_rad_q      <= '0;
      issue_id_q      <= '0;
    end else begin
      cord_valid_in_q <= xfer;
      if (xfer) begin
        cord_rad_q <= req_rad_i[gnt_id];
        issue_id_q <= gnt_id;
      end
    end
  end

  // Entry k is visible k+1 cycles after issue, so the head lines up with cord_valid_out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < CORDIC_LATENCY; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= '{valid: cord_valid_in_q, id: TagIdW'(issue_id_q)};
      for (int unsigned k = 1; k < CORDIC_LATENCY; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign head          = tag_q[CORDIC_LATENCY-1];
  assign unused_tag_id = ^head.id;
  assign res_hit       = cord_valid_out_i & head.valid;

  always_comb begin
    res_valid_d = '0;
    res_sin_d   = res_sin_q;
    res_cos_d   = res_cos_q;
    res_id_d    = res_id_q;
    if (res_hit) begin
      res_valid_d = NUM_REQ'(1) << head.id[ID_W-1:0];
      res_sin_d   = cord_s_out_i;
      res_cos_d   = cord_c_out_i;
      res_id_d    = head.id[ID_W-1:0];
    end
    // Any strobe/tag disagreement (dropped result or untagged stray) latches until reset.
    tag_err_d = tag_err_q | (cord_valid_out_i ^ head.valid);
  end

  // Counts tags in the shadow pipe; a tag retires at the head whether or not data arrived.
  always_comb begin
    in_flight_d = in_flight_q;
    unique case ({cord_valid_in_q, head.valid})
      2'b10:   in_flight_d = in_flight_q + IfW'(1);
      2'b01:   in_flight_d = in_flight_q - IfW'(1);
      default: in_flight_d = in_flight_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_valid_q <= '0;
      res_sin_q   <= '0;
      res_cos_q   <= '0;
      res_id_q    <= '0;
      in_flight_q <= '0;
      tag_err_q   <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_sin_q   <= res_sin_d;
      res_cos_q   <= res_cos_d;
      res_id_q    <= res_id_d;
      in_flight_q <= in_flight_d;
      tag_err_q   <= tag_err_d;
    end
  end

  assign cord_rad_o      = cord_rad_q;
  assign cord_valid_in_o = cord_valid_in_q;
  assign res_valid_o     = res_valid_q;
  assign res_sin_o       = res_sin_q;
  assign res_cos_o       = res_cos_q;
  assign res_id_o        = res_id_q;
  assign in_flight_o     = in_flight_q;
  assign tag_err_o       = tag_err_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: a stub CORDIC (fixed-latency delay line, optional drop) feeds the
// DUT; a transaction-level model predicts grants, result timing/ownership, in-flight count and
// the sticky error flag from the scheduling rules.
module tb_cordic_sched;

  localparam int unsigned N    = 4;
  localparam int unsigned L    = 16;
  localparam int unsigned IDW  = 2;
  localparam int unsigned IFW  = $clog2(L + 2);
  localparam int          MAXC = 1024;

  logic                clk       = 1'b0;
  logic                rst_n     = 1'b0;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0][31:0]  req_rad   = '0;
  logic                hold      = 1'b0;
  logic [N-1:0]        req_ready;
  logic [31:0]         cord_rad;
  logic                cord_valid_in;
  logic [15:0]         cord_s_out, cord_c_out;
  logic                cord_valid_out;
  logic [N-1:0]        res_valid;
  logic [15:0]         res_sin, res_cos;
  logic [IDW-1:0]      res_id;
  logic [IFW-1:0]      in_flight;
  logic                tag_err;

  always #5 clk = ~clk;

  cordic_sched #(
    .NUM_REQ        (N),
    .CORDIC_LATENCY (L),
    .ID_W           (IDW)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_rad_i        (req_rad),
    .req_ready_o      (req_ready),
    .hold_i           (hold),
    .cord_rad_o       (cord_rad),
    .cord_valid_in_o  (cord_valid_in),
    .cord_s_out_i     (cord_s_out),
    .cord_c_out_i     (cord_c_out),
    .cord_valid_out_i (cord_valid_out),
    .res_valid_o      (res_valid),
    .res_sin_o        (res_sin),
    .res_cos_o        (res_cos),
    .res_id_o         (res_id),
    .in_flight_o      (in_flight),
    .tag_err_o        (tag_err)
  );

  // Stub CORDIC: not reset, so items issued before a reset still emerge afterwards.
  logic [L-1:0] st_v = '0;
  logic [L-1:0] st_d = '0;
  logic [31:0]  st_r [L];
  logic [31:0]  st_head;
  logic         drop_flag = 1'b0;

  always @(posedge clk) begin
    st_v    <= {st_v[L-2:0], cord_valid_in};
    st_d    <= {st_d[L-2:0], cord_valid_in & drop_flag};
    st_r[0] <= cord_rad;
    for (int k = 1; k < L; k++) st_r[k] <= st_r[k-1];
  end

  assign st_head        = st_r[L-1];
  assign cord_valid_out = st_v[L-1] & ~st_d[L-1];
  assign cord_s_out     = st_head[31:16];
  assign cord_c_out     = st_head[15:0] ^ 16'hA5A5;

  // Reference model state.
  int          n_checks = 0;
  int          n_err    = 0;
  int          cyc      = 0;
  bit          in_rst   = 1'b1;
  int          last_gnt = N - 1;
  logic [31:0] exp_rad  = '0;
  logic [15:0] exp_sin  = '0;
  logic [15:0] exp_cos  = '0;
  int          exp_id   = 0;
  bit          exp_err  = 1'b0;
  bit          drop_req = 1'b0;
  bit          xv     [MAXC];
  bit          xdrop  [MAXC];
  bit          xkill  [MAXC];
  bit          xstale [MAXC];
  int          xid    [MAXC];
  logic [31:0] xrad   [MAXC];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Next requester after the last granted one that is asking; -1 if none may be granted.
  function automatic int model_grant();
    if (in_rst || hold) return -1;
    for (int k = 1; k <= int'(N); k++) begin
      int i;
      i = (last_gnt + k) % int'(N);
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_regs();
    int          t;
    int          nf;
    logic [N-1:0] exp_rv;
    logic [31:0] r;
    if (in_rst) begin
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_cord_valid_in", 32'(cord_valid_in), 0);
      chk("rst_cord_rad", cord_rad, 0);
      chk("rst_res_valid", 32'(res_valid), 0);
      chk("rst_res_sin", 32'(res_sin), 0);
      chk("rst_res_cos", 32'(res_cos), 0);
      chk("rst_res_id", 32'(res_id), 0);
      chk("rst_in_flight", 32'(in_flight), 0);
      chk("rst_tag_err", 32'(tag_err), 0);
    end else begin
      exp_rv = '0;
      t = cyc - int'(L) - 2;
      if (t >= 0 && xv[t] && !xkill[t]) begin
        if (xdrop[t]) begin
          exp_err = 1'b1;
        end else begin
          exp_rv[xid[t]] = 1'b1;
          r       = xrad[t];
          exp_sin = r[31:16];
          exp_cos = r[15:0] ^ 16'hA5A5;
          exp_id  = xid[t];
        end
      end
      if (t >= 0 && xv[t] && xkill[t] && xstale[t]) exp_err = 1'b1;
      nf = 0;
      for (int s = cyc - int'(L) - 1; s <= cyc - 2; s++) begin
        if (s >= 0 && xv[s] && !xkill[s]) nf++;
      end
      chk("cord_valid_in", 32'(cord_valid_in), (cyc >= 1 && xv[cyc-1]) ? 1 : 0);
      chk("cord_rad", cord_rad, exp_rad);
      chk("res_valid", 32'(res_valid), 32'(exp_rv));
      chk("res_sin", 32'(res_sin), 32'(exp_sin));
      chk("res_cos", 32'(res_cos), 32'(exp_cos));
      chk("res_id", 32'(res_id), exp_id);
      chk("in_flight", 32'(in_flight), nf);
      chk("tag_err", 32'(tag_err), 32'(exp_err));
    end
  endtask

  // One clock: check the combinational grant, record the transfer, then check registered state.
  task automatic tick();
    int g;
    #1;
    g = model_grant();
    chk("req_ready", 32'(req_ready), (g < 0) ? 0 : (1 << g));
    if (g >= 0) begin
      xv[cyc]    = 1'b1;
      xid[cyc]   = g;
      xrad[cyc]  = req_rad[g];
      xdrop[cyc] = drop_req;
      drop_req   = 1'b0;
      last_gnt   = g;
      exp_rad    = req_rad[g];
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    drop_flag = xv[cyc-1] && xdrop[cyc-1];
    check_regs();
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    hold      = 1'b0;
    repeat (n) tick();
  endtask

  task automatic rand_rads();
    for (int k = 0; k < int'(N); k++) req_rad[k] = $urandom;
  endtask

  task automatic do_reset(input int n);
    int r0;
    rst_n     = 1'b0;
    in_rst    = 1'b1;
    drop_flag = 1'b0;
    #1;
    check_regs();
    r0 = cyc;
    for (int t = 0; t < r0; t++) if (xv[t]) xkill[t] = 1'b1;
    last_gnt = N - 1;
    exp_rad  = '0;
    exp_sin  = '0;
    exp_cos  = '0;
    exp_id   = 0;
    exp_err  = 1'b0;
    repeat (n) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_regs();
    end
    // Stub items already past the issue register and emerging after release hit an empty tag.
    for (int t = 0; t < r0; t++) begin
      xstale[t] = xkill[t] && (t <= r0 - 2) && (t + int'(L) + 1 >= cyc);
    end
    rst_n  = 1'b1;
    in_rst = 1'b0;
  endtask

  initial begin
    do_reset(3);

    // Single request from requester 0.
    req_valid  = 4'b0001;
    req_rad[0] = 32'h3243F6A8;
    tick();
    idle(L + 4);

    // All four requesters for 8 cycles: rotating grants.
    req_valid = 4'hF;
    repeat (8) begin
      rand_rads();
      tick();
    end
    idle(L + 4);

    // Hold for 5 cycles in the middle of a stream.
    req_valid = 4'hF;
    repeat (6) begin rand_rads(); tick(); end
    hold = 1'b1;
    repeat (5) begin rand_rads(); tick(); end
    hold = 1'b0;
    repeat (6) begin rand_rads(); tick(); end
    idle(L + 4);

    // Random traffic with occasional hold.
    repeat (60) begin
      req_valid = N'($urandom_range(0, 15));
      hold      = ($urandom_range(0, 9) == 0);
      rand_rads();
      tick();
    end
    idle(L + 4);

    // One requester continuously valid, with a single hold cycle.
    req_valid = 4'b0100;
    repeat (5) begin rand_rads(); tick(); end
    hold = 1'b1;
    tick();
    hold = 1'b0;
    repeat (5) begin rand_rads(); tick(); end
    idle(L + 4);

    // Stub drops one result: error latches and that result never pulses.
    req_valid = 4'b1011;
    repeat (3) begin rand_rads(); tick(); end
    drop_req = 1'b1;
    repeat (5) begin rand_rads(); tick(); end
    idle(L + 4);

    // Reset with items in flight; stale stub results afterwards must flag an error.
    req_valid = 4'hF;
    repeat (7) begin rand_rads(); tick(); end
    do_reset(2);
    idle(L + 4);

    // Scheduler still delivers after the error; pointer restarted at requester 0.
    req_valid = 4'b0011;
    rand_rads();
    tick();
    idle(L + 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
